ct_f_spsram_shadow: RTL and testbench

CT_F_SPSRAM_SHADOW -- requirements
Module: ct_f_spsram_shadow

---
 rtl/ct_f_spsram_shadow.sv | 150 +++++++++++++++
 tb/tb_ct_f_spsram_shadow.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_shadow.sv
// Single-port SRAM model with a bit-parallel taint (shadow) array.
// After reset an INIT sweep clears the shadow array, one word per cycle;
// the data array is left as is. In RUN the block accepts one read or one
// masked write per cycle and propagates taint from data, mask, control
// and address inputs.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   A / A_t0          address and its taint
//   CEN / CEN_t0      chip enable (active-low) and its taint
//   GWEN / GWEN_t0    global write enable (active-low) and its taint
//   WEN / WEN_t0      per-bit write mask (active-low) and its taint
//   D / D_t0          write data and its taint
//   Q / Q_t0          read data and its taint, latency 1 + RD_PIPE
//   INIT_BUSY         high while the shadow clear sweep runs
module ct_f_spsram_shadow #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned RD_PIPE    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  INIT_BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] sh  [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rd_t0_q, rd_t0_d;

  logic                  mem_we, sh_we;
  logic [ADDR_WIDTH-1:0] sh_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, sh_wdata;
  logic [DATA_WIDTH-1:0] rd_data, rd_sh;
  logic                  ctl_taint;

  assign rd_data   = mem[A];
  assign rd_sh     = sh[A];
  assign ctl_taint = (|A_t0) | CEN_t0 | GWEN_t0;

  // Next-state, sweep, array write and first read stage.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    rd_t0_d   = rd_t0_q;
    mem_we    = 1'b0;
    sh_we     = 1'b0;
    sh_addr   = A;
    mem_wdata = (rd_data & WEN) | (D & ~WEN);
    sh_wdata  = ((D_t0 | WEN_t0 | {DATA_WIDTH{ctl_taint}}) & ~WEN)
              | ((WEN_t0 | rd_sh) & WEN);
    if (state_q == ST_INIT) begin
      // Requests are ignored; the read path is pinned to zero.
      sh_we    = !RST;
      sh_addr  = cnt_q;
      sh_wdata = '0;
      cnt_d    = cnt_q + ADDR_WIDTH'(1);
      rd_d     = '0;
      rd_t0_d  = '0;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_RUN;
      end
    end else if (!CEN && !GWEN) begin
      mem_we = !RST;
      sh_we  = !RST;
    end else if (!CEN) begin
      rd_d    = rd_data;
      rd_t0_d = rd_sh | {DATA_WIDTH{ctl_taint}};
    end else if (CEN_t0) begin
      // A tainted deselect taints the held output.
      rd_t0_d = '1;
    end
    busy_d = (state_d == ST_INIT);
  end

  // Control and first read stage registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      rd_q    <= '0;
      rd_t0_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      rd_t0_q <= rd_t0_d;
    end
  end

  // Storage arrays; not reset, the shadow is cleared by the sweep.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[A]     <= mem_wdata;
    if (sh_we)  sh[sh_addr] <= sh_wdata;
  end

  generate
    if (RD_PIPE == 0) begin : g_nopipe
      assign Q    = rd_q;
      assign Q_t0 = rd_t0_q;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] pq_q, pq_d;
      logic [DATA_WIDTH-1:0] pt_q, pt_d;

      // Extra output stage advances every cycle.
      always_comb begin
        pq_d = rd_q;
        pt_d = rd_t0_q;
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          pq_q <= '0;
          pt_q <= '0;
        end else begin
          pq_q <= pq_d;
          pt_q <= pt_d;
        end
      end

      assign Q    = pq_q;
      assign Q_t0 = pt_q;
    end
  endgenerate

  assign INIT_BUSY = busy_q;

endmodule

// File: tb/tb_ct_f_spsram_shadow.sv
module tb_ct_f_spsram_shadow;

  logic       CLK;
  logic       RST;
  logic [3:0] A, A_t0;
  logic       CEN, CEN_t0, GWEN, GWEN_t0;
  logic [7:0] WEN, WEN_t0, D, D_t0;
  logic [7:0] q0, qt0, q1, qt1;
  logic       busy0, busy1;

  int checks   = 0;
  int failures = 0;

  ct_f_spsram_shadow #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_PIPE(0)) u_p0 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D),
    .D_t0(D_t0), .Q(q0), .Q_t0(qt0), .INIT_BUSY(busy0));

  ct_f_spsram_shadow #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_PIPE(1)) u_p1 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D),
    .D_t0(D_t0), .Q(q1), .Q_t0(qt1), .INIT_BUSY(busy1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, shadow contents, remaining sweep
  // cycles and the value each output must show.
  logic [7:0] mem_m [16];
  logic [7:0] sh_m  [16];
  int         init_left = 0;
  bit         valid = 0;
  logic [7:0] exp_q = 0, exp_t = 0, exp_q1 = 0, exp_t1 = 0;

  initial begin : model
    logic ctl;
    forever begin
      @(posedge CLK);
      if (RST) begin
        init_left = 16;
        exp_q = 0; exp_t = 0; exp_q1 = 0; exp_t1 = 0;
        valid = 1;
      end else if (init_left != 0) begin
        sh_m[4'(16 - init_left)] = 8'h00;
        init_left--;
        exp_q1 = exp_q; exp_t1 = exp_t;
      end else begin
        exp_q1 = exp_q; exp_t1 = exp_t;
        ctl = (A_t0 != 0) || CEN_t0 || GWEN_t0;
        if (!CEN && !GWEN) begin
          for (int i = 0; i < 8; i++) begin
            if (!WEN[i]) begin
              mem_m[A][i] = D[i];
              sh_m[A][i]  = D_t0[i] | WEN_t0[i] | ctl;
            end else begin
              sh_m[A][i]  = WEN_t0[i] | sh_m[A][i];
            end
          end
        end else if (!CEN) begin
          exp_q = mem_m[A];
          exp_t = ctl ? 8'hFF : sh_m[A];
        end else if (CEN_t0) begin
          exp_t = 8'hFF;
        end
      end
    end
  end

  // Compare process, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge CLK);
      if (valid) begin
        chk("busy_p0", 32'(busy0), 32'(init_left != 0));
        chk("busy_p1", 32'(busy1), 32'(init_left != 0));
        chk("q_p0",  32'(q0),  32'(exp_q));
        chk("qt_p0", 32'(qt0), 32'(exp_t));
        chk("q_p1",  32'(q1),  32'(exp_q1));
        chk("qt_p1", 32'(qt1), 32'(exp_t1));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; A = 0; A_t0 = 0; CEN = 1; CEN_t0 = 0; GWEN = 1; GWEN_t0 = 0;
    WEN = 8'hFF; WEN_t0 = 0; D = 0; D_t0 = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    step();
    RST = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    input logic [7:0] wen, input logic [7:0] dt);
    idle();
    A = a; D = d; WEN = wen; D_t0 = dt; CEN = 0; GWEN = 0;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] at);
    idle();
    A = a; A_t0 = at; CEN = 0; GWEN = 1;
    step();
  endtask

  // Counts cycles with INIT_BUSY high; optionally issues writes meanwhile.
  task automatic count_busy(input bit with_writes, output int n);
    n = 0;
    while (busy0 && n < 40) begin
      chk("init_q",  32'(q0),  32'h0);
      chk("init_qt", 32'(qt0), 32'h0);
      idle();
      if (with_writes) begin
        A = 4'($urandom); D = 8'($urandom); WEN = 8'h00; CEN = 0; GWEN = 0;
      end
      n++;
      step();
    end
    idle();
  endtask

  initial begin : stim
    int n;
    idle();
    do_reset();
    chk("rst_busy", 32'(busy0), 32'h1);
    chk("rst_q",    32'(q0),    32'h0);
    chk("rst_qt1",  32'(qt1),   32'h0);
    count_busy(0, n);
    chk("sweep_len", 32'(n), 32'd16);

    for (int a = 0; a < 16; a++) wr(4'(a), 8'($urandom), 8'h00, 8'h00);
    idle(); step();

    // Writes during the sweep must not reach memory.
    do_reset();
    count_busy(1, n);
    chk("sweep_len_wr", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) rd(4'(a), 4'h0);

    wr(4'd3, 8'hA5, 8'h00, 8'h0F);
    rd(4'd3, 4'h0);
    chk("rw_q",  32'(q0),  32'hA5);
    chk("rw_qt", 32'(qt0), 32'h0F);

    wr(4'd3, 8'hFF, 8'hF0, 8'h00);
    rd(4'd3, 4'h0);
    chk("mask_q",  32'(q0),  32'hAF);
    chk("mask_qt", 32'(qt0), 32'h00);
    rd(4'd3, 4'h1);
    chk("at_qt", 32'(qt0), 32'hFF);
    chk("at_q",  32'(q0),  32'hAF);

    wr(4'd3, 8'h00, 8'h00, 8'hFF);
    do_reset();
    idle();
    repeat (7) step();
    do_reset();
    count_busy(0, n);
    chk("restart_len", 32'(n), 32'd16);
    rd(4'd3, 4'h0);
    chk("restart_qt", 32'(qt0), 32'h00);

    wr(4'd1, 8'h11, 8'h00, 8'h00);
    wr(4'd2, 8'h22, 8'h00, 8'h00);
    wr(4'd3, 8'h33, 8'h00, 8'h00);
    rd(4'd1, 4'h0);
    rd(4'd2, 4'h0);
    chk("pipe_c2", 32'(q1), 32'h11);
    rd(4'd3, 4'h0);
    chk("pipe_c3", 32'(q1), 32'h22);
    idle(); step();
    chk("pipe_c4", 32'(q1), 32'h33);
    step();
    chk("pipe_hold", 32'(q1), 32'h33);

    for (int c = 0; c < 400; c++) begin
      RST     = ($urandom_range(99) == 0);
      A       = 4'($urandom);
      A_t0    = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      CEN     = ($urandom_range(3) == 0);
      CEN_t0  = ($urandom_range(7) == 0);
      GWEN    = 1'($urandom_range(1));
      GWEN_t0 = ($urandom_range(7) == 0);
      WEN     = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      WEN_t0  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
      D       = 8'($urandom);
      D_t0    = ($urandom_range(1) == 0) ? 8'($urandom) : 8'h00;
      step();
    end
    idle();
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
